// File: rtl/fir_pkg.sv
// Shared types and width helpers for the time-multiplexed multi-channel FIR filter.
package fir_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } fir_state_e;

  // Per-tap control token that travels alongside the datapath pipeline.
  typedef struct packed {
    logic vld;
    logic first;
    logic last;
  } tap_ctl_t;

  function automatic int ch_bits(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 0;
  endfunction

  function automatic int ch_idx_w(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

  function automatic int addr_w(input int n_ch, input int n_taps);
    return ch_bits(n_ch) + $clog2(n_taps);
  endfunction

  function automatic int prod_w(input int data_w, input int coef_w);
    return data_w + coef_w;
  endfunction

  function automatic int acc_w(input int data_w, input int coef_w, input int n_taps);
    return prod_w(data_w, coef_w) + $clog2(n_taps);
  endfunction

  function automatic longint sat_hi(input int data_w);
    return (longint'(1) <<< (data_w - 1)) - longint'(1);
  endfunction

  function automatic longint sat_lo(input int data_w);
    return -(longint'(1) <<< (data_w - 1));
  endfunction

endpackage

// File: rtl/fir_sat_shift.sv
// Rescales the accumulator by COEF_FRAC, saturates to DATA_W and registers the result.
module fir_sat_shift import fir_pkg::*; #(
  parameter int N_CH      = 2,
  parameter int DATA_W    = 24,
  parameter int ACC_W     = 67,
  parameter int COEF_FRAC = 31
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    acc_done,
  input  logic signed [ACC_W-1:0] acc,
  input  logic [N_CH-1:0]         ch_oh,
  output logic [N_CH-1:0]         dout_valid,
  output logic [DATA_W-1:0]       dout,
  output logic                    dout_sat
);

  localparam logic signed [ACC_W-1:0] HI = ACC_W'(sat_hi(DATA_W));
  localparam logic signed [ACC_W-1:0] LO = ACC_W'(sat_lo(DATA_W));

  logic signed [ACC_W-1:0] shifted;
  logic [DATA_W-1:0]       sat_val;
  logic                    sat_flag;

  // Arithmetic shift drops fraction bits, i.e. truncates toward minus infinity.
  assign shifted = acc >>> COEF_FRAC;

  // NOTE: defaults first, so every path assigns every output and no latch appears.
  always_comb begin
    sat_val  = shifted[DATA_W-1:0];
    sat_flag = 1'b0;
    if (shifted > HI) begin
      sat_val  = HI[DATA_W-1:0];
      sat_flag = 1'b1;
    end else if (shifted < LO) begin
      sat_val  = LO[DATA_W-1:0];
      sat_flag = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_valid <= '0;
      dout       <= '0;
      dout_sat   <= 1'b0;
    end else begin
      dout_valid <= acc_done ? ch_oh : '0;
      if (acc_done) begin
        dout     <= sat_val;
        dout_sat <= sat_flag;
      end
    end
  end

endmodule

// File: rtl/mul_pipe.sv
// Signed A_W x B_W multiplier with LAT output pipeline registers.
module mul_pipe #(
  parameter int A_W = 24,
  parameter int B_W = 35,
  parameter int LAT = 3
) (
  input  logic                        clk,
  input  logic signed [A_W-1:0]       a,
  input  logic signed [B_W-1:0]       b,
  output logic signed [A_W+B_W-1:0]   p
);

  logic signed [A_W+B_W-1:0] pipe [LAT];

  always_ff @(posedge clk) begin
    pipe[0] <= a * b;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end

  assign p = pipe[LAT-1];

endmodule

// File: rtl/ram.sv
// Simple dual-port RAM: one write port, one registered read port, read-old on collision.
module ram #(
  parameter int W  = 24,
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [2**AW];

  // NOTE: the array has no reset; clearing is done by the owner, and a reset
  // port here would stop the memory mapping onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/fir_filter_mc.sv
// Time-multiplexed N_CH-channel FIR: one MAC per clock, one convolution in flight,
// run-time coefficient loading and reset-time clearing of the sample history.
module fir_filter_mc import fir_pkg::*; #(
  parameter int    N_CH      = 2,
  parameter int    N_TAPS    = 256,
  parameter int    DATA_W    = 24,
  parameter int    COEF_W    = 35,
  parameter int    COEF_FRAC = 31,
  parameter int    MUL_LAT   = 3,
  parameter string COEF_INIT = ""
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [N_CH-1:0]                   din_valid,
  input  logic [DATA_W-1:0]                 din,
  output logic                              din_ready,
  input  logic                              coef_we,
  input  logic [addr_w(N_CH, N_TAPS)-1:0]   coef_addr,
  input  logic [COEF_W-1:0]                 coef_din,
  output logic [N_CH-1:0]                   dout_valid,
  output logic [DATA_W-1:0]                 dout,
  output logic                              dout_sat,
  output logic                              drop_err
);

  localparam int TAP_W    = $clog2(N_TAPS);
  localparam int CHI_W    = ch_idx_w(N_CH);
  localparam int ADDR_W   = addr_w(N_CH, N_TAPS);
  localparam int P_W      = prod_w(DATA_W, COEF_W);
  localparam int ACC_W    = acc_w(DATA_W, COEF_W, N_TAPS);
  localparam int CLR_LAST = N_CH * N_TAPS - 1;

  function automatic logic [ADDR_W-1:0] mk_addr(input logic [CHI_W-1:0] ch,
                                                input logic [TAP_W-1:0] ptr);
    return ADDR_W'({ch, ptr});
  endfunction

  fir_state_e         state;
  logic [ADDR_W-1:0]  clr_cnt;
  logic [TAP_W-1:0]   wr_ptr [N_CH];
  logic [CHI_W-1:0]   cur_ch;
  logic [TAP_W-1:0]   rd_ptr;
  logic [TAP_W-1:0]   tap_cnt;

  logic [CHI_W-1:0]   din_ch;
  logic               din_onehot;
  logic               accept;
  logic               coef_ok;

  logic               smp_we;
  logic [ADDR_W-1:0]  smp_waddr;
  logic [DATA_W-1:0]  smp_wdata;
  logic [DATA_W-1:0]  smp_rdata;
  logic [COEF_W-1:0]  coef_rdata;

  tap_ctl_t           ctl_pipe [MUL_LAT+1];
  logic signed [P_W-1:0]   prod;
  logic signed [ACC_W-1:0] acc;
  logic               acc_done;

  always_comb begin
    din_ch = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (din_valid[i]) din_ch = CHI_W'(i);
    end
  end

  assign din_onehot = $onehot(din_valid);
  assign accept     = !rst && din_ready && din_onehot;
  assign coef_ok    = !rst && din_ready && coef_we;

  // The write port is shared by the reset-time clear sweep and sample acceptance.
  assign smp_we    = (!rst && state == ST_CLEAR) || accept;
  assign smp_waddr = (state == ST_CLEAR) ? clr_cnt : mk_addr(din_ch, wr_ptr[din_ch]);
  assign smp_wdata = (state == ST_CLEAR) ? '0 : din;

  ram #(.W(DATA_W), .AW(ADDR_W)) u_smp_ram (
    .clk   (clk),
    .we    (smp_we),
    .waddr (smp_waddr),
    .wdata (smp_wdata),
    .raddr (mk_addr(cur_ch, rd_ptr)),
    .rdata (smp_rdata)
  );

  ram #(.W(COEF_W), .AW(ADDR_W)) u_coef_ram (
    .clk   (clk),
    .we    (coef_ok),
    .waddr (coef_addr),
    .wdata (coef_din),
    .raddr (mk_addr(cur_ch, tap_cnt)),
    .rdata (coef_rdata)
  );

  mul_pipe #(.A_W(DATA_W), .B_W(COEF_W), .LAT(MUL_LAT)) u_mul (
    .clk (clk),
    .a   (smp_rdata),
    .b   (coef_rdata),
    .p   (prod)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_CLEAR;
      clr_cnt   <= '0;
      for (int i = 0; i < N_CH; i++) wr_ptr[i] <= '0;
      cur_ch    <= '0;
      rd_ptr    <= '0;
      tap_cnt   <= '0;
      din_ready <= 1'b0;
      drop_err  <= 1'b0;
    end else begin
      drop_err <= ((|din_valid) && !(din_ready && din_onehot)) || (coef_we && !din_ready);
      case (state)
        ST_CLEAR: begin
          clr_cnt <= clr_cnt + ADDR_W'(1);
          if (clr_cnt == ADDR_W'(CLR_LAST)) begin
            state     <= ST_IDLE;
            din_ready <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (accept) begin
            state          <= ST_RUN;
            din_ready      <= 1'b0;
            cur_ch         <= din_ch;
            rd_ptr         <= wr_ptr[din_ch];
            wr_ptr[din_ch] <= wr_ptr[din_ch] + TAP_W'(1);
            tap_cnt        <= '0;
          end
        end
        ST_RUN: begin
          tap_cnt <= tap_cnt + TAP_W'(1);
          rd_ptr  <= rd_ptr - TAP_W'(1);
          if (tap_cnt == TAP_W'(N_TAPS - 1)) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (acc_done) begin
            state     <= ST_IDLE;
            din_ready <= 1'b1;
          end
        end
        default: state <= ST_CLEAR;
      endcase
    end
  end

  // The token leaves stage 0 with the RAM data and meets the product MUL_LAT cycles later.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= MUL_LAT; i++) ctl_pipe[i] <= '0;
      acc_done <= 1'b0;
    end else begin
      ctl_pipe[0] <= '{vld:   state == ST_RUN,
                       first: tap_cnt == '0,
                       last:  tap_cnt == TAP_W'(N_TAPS - 1)};
      for (int i = 1; i <= MUL_LAT; i++) ctl_pipe[i] <= ctl_pipe[i-1];
      acc_done <= ctl_pipe[MUL_LAT].vld && ctl_pipe[MUL_LAT].last;
    end
  end

  always_ff @(posedge clk) begin
    if (ctl_pipe[MUL_LAT].vld) begin
      acc <= ctl_pipe[MUL_LAT].first ? ACC_W'(prod) : acc + ACC_W'(prod);
    end
  end

  fir_sat_shift #(
    .N_CH      (N_CH),
    .DATA_W    (DATA_W),
    .ACC_W     (ACC_W),
    .COEF_FRAC (COEF_FRAC)
  ) u_sat (
    .clk        (clk),
    .rst        (rst),
    .acc_done   (acc_done),
    .acc        (acc),
    .ch_oh      (N_CH'(1) << cur_ch),
    .dout_valid (dout_valid),
    .dout       (dout),
    .dout_sat   (dout_sat)
  );

endmodule

// File: tb/tb_fir_filter_mc.sv
// Self-checking bench: a direct-convolution model feeds a scoreboard queue of expected results.
module tb_fir_filter_mc;

  localparam int N_CH      = 2;
  localparam int N_TAPS    = 256;
  localparam int DATA_W    = 24;
  localparam int COEF_W    = 35;
  localparam int COEF_FRAC = 31;
  localparam int MUL_LAT   = 3;
  localparam int LAT       = N_TAPS + MUL_LAT + 3;
  localparam int CLR_CYC   = N_CH * N_TAPS;

  localparam logic [COEF_W-1:0] C_ONE     = 35'h0_8000_0000;
  localparam logic [COEF_W-1:0] C_HALF    = 35'h0_4000_0000;
  localparam logic [COEF_W-1:0] C_NEG_ONE = 35'h7_8000_0000;

  logic              clk = 1'b0;
  logic              rst;
  logic [N_CH-1:0]   din_valid;
  logic [DATA_W-1:0] din;
  logic              din_ready;
  logic              coef_we;
  logic [8:0]        coef_addr;
  logic [COEF_W-1:0] coef_din;
  logic [N_CH-1:0]   dout_valid;
  logic [DATA_W-1:0] dout;
  logic              dout_sat;
  logic              drop_err;

  int     checks = 0;
  int     errors = 0;
  longint cyc    = 0;

  typedef struct {
    int              ch;
    logic [DATA_W-1:0] d;
    logic            sat;
    longint          at;
  } exp_t;

  exp_t sb[$];

  logic signed [COEF_W-1:0] m_coef [N_CH][N_TAPS];
  logic signed [DATA_W-1:0] m_hist [N_CH][N_TAPS];
  int                       m_ptr  [N_CH];

  fir_filter_mc #(
    .N_CH(N_CH), .N_TAPS(N_TAPS), .DATA_W(DATA_W), .COEF_W(COEF_W),
    .COEF_FRAC(COEF_FRAC), .MUL_LAT(MUL_LAT), .COEF_INIT("")
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .din_valid  (din_valid),
    .din        (din),
    .din_ready  (din_ready),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_din   (coef_din),
    .dout_valid (dout_valid),
    .dout       (dout),
    .dout_sat   (dout_sat),
    .drop_err   (drop_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at cycle %0d, need finish", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int c = 0; c < N_CH; c++) begin
      m_ptr[c] = 0;
      for (int k = 0; k < N_TAPS; k++) m_hist[c][k] = '0;
    end
  endtask

  // Direct convolution of the channel history with its coefficients.
  task automatic model_accept(input int ch, input logic [DATA_W-1:0] d, input longint at);
    logic signed [79:0] acc;
    logic signed [79:0] sh;
    exp_t e;
    m_hist[ch][m_ptr[ch]] = d;
    acc = '0;
    for (int k = 0; k < N_TAPS; k++) begin
      acc += 80'(m_hist[ch][(m_ptr[ch] - k) & (N_TAPS - 1)]) * 80'(m_coef[ch][k]);
    end
    m_ptr[ch] = (m_ptr[ch] + 1) % N_TAPS;
    sh = acc >>> COEF_FRAC;
    e.ch = ch;
    e.at = at;
    if (sh > 80'sd8388607) begin
      e.d = 24'h7fffff; e.sat = 1'b1;
    end else if (sh < -80'sd8388608) begin
      e.d = 24'h800000; e.sat = 1'b1;
    end else begin
      e.d = sh[DATA_W-1:0]; e.sat = 1'b0;
    end
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && dout_valid !== '0) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: dout_valid=%b dout=%h at cycle %0d, need no result",
                 dout_valid, dout, cyc);
      end else begin
        e = sb.pop_front();
        if (dout_valid !== 2'(1 << e.ch) || dout !== e.d || dout_sat !== e.sat) begin
          errors++;
          $display("FAIL result: valid=%b dout=%h sat=%b, need valid=%b dout=%h sat=%b",
                   dout_valid, dout, dout_sat, 2'(1 << e.ch), e.d, e.sat);
        end
        checks++;
        if (cyc != e.at) begin
          errors++;
          $display("FAIL latency: result at cycle %0d, need %0d", cyc, e.at);
        end
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (din_ready !== 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    checks++;
    if (din_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_timeout: din_ready=%b after %0d cycles, need 1", din_ready, n);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    wait_ready();
    while (sb.size() != 0 && n < 2000) begin
      tick();
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d results pending, need 0", sb.size());
    end
  endtask

  task automatic send(input int ch, input logic [DATA_W-1:0] d);
    wait_ready();
    din_valid = 2'(1 << ch);
    din       = d;
    model_accept(ch, d, cyc + LAT);
    tick();
    din_valid = '0;
  endtask

  task automatic coef_wr(input int ch, input int tap, input logic [COEF_W-1:0] val, input bit ok);
    if (ok) wait_ready();
    coef_we   = 1'b1;
    coef_addr = 9'(ch * N_TAPS + tap);
    coef_din  = val;
    if (ok) m_coef[ch][tap] = val;
    tick();
    coef_we = 1'b0;
  endtask

  task automatic test_reset();
    int bad = 0;
    din_valid = '0;
    coef_we   = 1'b0;
    rst       = 1'b1;
    repeat (3) tick();
    checks++;
    if (din_ready !== 1'b0 || dout_valid !== '0 || dout !== '0 || dout_sat !== 1'b0 || drop_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: ready=%b valid=%b dout=%h sat=%b drop=%b, need all 0",
               din_ready, dout_valid, dout, dout_sat, drop_err);
    end
    model_clear();
    rst = 1'b0;
    for (int i = 0; i < CLR_CYC; i++) begin
      if (din_ready !== 1'b0 || dout_valid !== '0 || dout !== '0 || dout_sat !== 1'b0 || drop_err !== 1'b0)
        bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL clear_outputs: %0d cycles with nonzero outputs during clear, need 0", bad);
    end
    checks++;
    if (din_ready !== 1'b1) begin
      errors++;
      $display("FAIL clear_ready_rise: din_ready=%b at cycle %0d after release, need 1", din_ready, CLR_CYC);
    end
  endtask

  task automatic test_load();
    for (int c = 0; c < N_CH; c++)
      for (int k = 0; k < N_TAPS; k++) coef_wr(c, k, '0, 1'b1);
    coef_wr(0, 3, C_ONE, 1'b1);
  endtask

  task automatic test_impulse();
    send(0, 24'h400000);
    repeat (3) send(0, 24'h000000);
    wait_drain();
    checks++;
    if (dout !== 24'h400000) begin
      errors++;
      $display("FAIL impulse_delay: dout=%h, need 400000", dout);
    end
  endtask

  task automatic test_isolation();
    coef_wr(0, 3, '0, 1'b1);
    coef_wr(0, 0, C_HALF, 1'b1);
    coef_wr(1, 0, C_NEG_ONE, 1'b1);
    for (int i = 0; i < 2; i++) begin
      send(0, 24'h200000);
      send(1, 24'h100000);
    end
    wait_drain();
    checks++;
    if (dout !== 24'hF00000) begin
      errors++;
      $display("FAIL isolation_ch1: dout=%h, need f00000", dout);
    end
  endtask

  task automatic test_drops();
    send(0, 24'h040000);
    repeat (9) tick();
    din_valid = 2'b10;
    din       = 24'h123456;
    tick();
    din_valid = '0;
    checks++;
    if (drop_err !== 1'b1) begin
      errors++;
      $display("FAIL drop_din_busy: drop_err=%b, need 1", drop_err);
    end
    tick();
    checks++;
    if (drop_err !== 1'b0) begin
      errors++;
      $display("FAIL drop_pulse_width: drop_err=%b, need 0", drop_err);
    end
    coef_wr(0, 0, C_ONE, 1'b0);
    checks++;
    if (drop_err !== 1'b1) begin
      errors++;
      $display("FAIL drop_coef_busy: drop_err=%b, need 1", drop_err);
    end
    wait_drain();
    send(0, 24'h200000);
    wait_drain();
    checks++;
    if (dout !== 24'h100000) begin
      errors++;
      $display("FAIL coef_write_ignored: dout=%h, need 100000", dout);
    end
    wait_ready();
    din_valid = 2'b11;
    din       = 24'h000007;
    tick();
    din_valid = '0;
    checks++;
    if (drop_err !== 1'b1 || din_ready !== 1'b1) begin
      errors++;
      $display("FAIL drop_multi_hot: drop_err=%b din_ready=%b, need 1 1", drop_err, din_ready);
    end
    repeat (LAT + 5) tick();
  endtask

  task automatic test_saturation();
    for (int k = 0; k < N_TAPS; k++) coef_wr(1, k, C_ONE, 1'b1);
    repeat (3) send(1, 24'h7fffff);
    wait_drain();
    checks++;
    if (dout !== 24'h7fffff || dout_sat !== 1'b1) begin
      errors++;
      $display("FAIL sat_positive: dout=%h sat=%b, need 7fffff 1", dout, dout_sat);
    end
    test_reset();
    repeat (3) send(1, 24'h800000);
    wait_drain();
    checks++;
    if (dout !== 24'h800000 || dout_sat !== 1'b1) begin
      errors++;
      $display("FAIL sat_negative: dout=%h sat=%b, need 800000 1", dout, dout_sat);
    end
  endtask

  task automatic test_reset_mid_run();
    send(0, 24'h300000);
    repeat (99) tick();
    if (sb.size() > 0) void'(sb.pop_back());
    test_reset();
    send(1, 24'h000100);
    wait_drain();
    checks++;
    if (dout !== 24'h000100 || dout_sat !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_history: dout=%h sat=%b, need 000100 0", dout, dout_sat);
    end
    send(0, 24'h200000);
    wait_drain();
    checks++;
    if (dout !== 24'h100000) begin
      errors++;
      $display("FAIL post_reset_coefs: dout=%h, need 100000", dout);
    end
  endtask

  initial begin
    rst       = 1'b1;
    din_valid = '0;
    din       = '0;
    coef_we   = 1'b0;
    coef_addr = '0;
    coef_din  = '0;
    model_clear();
    test_reset();
    test_load();
    test_impulse();
    test_isolation();
    test_drops();
    test_saturation();
    test_reset_mid_run();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL pending_results: %0d expected results never arrived, need 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
